// File: rtl/lcd_write_sequencer.sv
// Character-LCD write sequencer: power-on init list, then one byte per valid/ready handshake.
// Optional macro LCD_LINE_WRAP_EN adds column/line tracking with automatic set-address commands.
module lcd_write_sequencer #(
  parameter int unsigned SETUP_CYC = 32'd2,
  parameter int unsigned EN_CYC    = 32'd12,
  parameter int unsigned HOLD_CYC  = 32'd2,
  parameter int unsigned CMD_WAIT  = 32'd2000,
  parameter int unsigned CLR_WAIT  = 32'd82000,
  parameter int unsigned PWR_WAIT  = 32'd750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_d
);

  typedef enum logic [2:0] {
    ST_PWR   = 3'd0,
    ST_SETUP = 3'd1,
    ST_ENHI  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_IDLE  = 3'd5
  } state_t;

  localparam logic [2:0] INIT_LAST = 3'd5;

  state_t      state_r;
  logic [31:0] cnt_r;
  logic [2:0]  init_idx_r;

`ifdef LCD_LINE_WRAP_EN
  logic [3:0]  col_r;
  logic        line_r;
  logic        wrap_pend_r;
`endif

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = 8'h38;
      3'd3:             b = 8'h0C;
      3'd4:             b = 8'h01;
      3'd5:             b = 8'h06;
      default:          b = 8'h38;
    endcase
    return b;
  endfunction

  // Clear and home commands need the long execution wait.
  function automatic logic [31:0] wait_len(input logic rs, input logic [7:0] d);
    logic [31:0] w;
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) begin
      w = CLR_WAIT;
    end else begin
      w = CMD_WAIT;
    end
    return w;
  endfunction

  assign lcd_rw = 1'b0;

  // Sequencer FSM: shared delay counter, bus outputs and handshake all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_PWR;
      cnt_r       <= 32'd0;
      init_idx_r  <= 3'd0;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_en      <= 1'b0;
      lcd_d       <= 8'h00;
`ifdef LCD_LINE_WRAP_EN
      col_r       <= 4'd0;
      line_r      <= 1'b0;
      wrap_pend_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        // Power-up delay counts up from the reset value of the counter.
        ST_PWR: begin
          if (cnt_r == PWR_WAIT - 32'd1) begin
            state_r    <= ST_SETUP;
            cnt_r      <= SETUP_CYC - 32'd1;
            init_idx_r <= 3'd0;
            lcd_rs     <= 1'b0;
            lcd_d      <= init_byte(3'd0);
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end

        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state_r   <= ST_SETUP;
            cnt_r     <= SETUP_CYC - 32'd1;
            lcd_rs    <= req_rs;
            lcd_d     <= req_data;
            req_ready <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
            if (req_rs) begin
              col_r       <= col_r + 4'd1;
              wrap_pend_r <= (col_r == 4'd15);
            end else if (req_data == 8'h01 || req_data == 8'h02 || req_data == 8'h03) begin
              col_r  <= 4'd0;
              line_r <= 1'b0;
            end else if (req_data[7]) begin
              col_r  <= req_data[3:0];
              line_r <= req_data[6];
            end else begin
              col_r <= col_r;
            end
`endif
          end else begin
            req_ready <= init_done;
          end
        end

        ST_SETUP: begin
          if (cnt_r == 32'd0) begin
            state_r <= ST_ENHI;
            cnt_r   <= EN_CYC - 32'd1;
            lcd_en  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end

        ST_ENHI: begin
          if (cnt_r == 32'd0) begin
            state_r <= ST_HOLD;
            cnt_r   <= HOLD_CYC - 32'd1;
            lcd_en  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end

        ST_HOLD: begin
          if (cnt_r == 32'd0) begin
            state_r <= ST_WAIT;
            cnt_r   <= wait_len(lcd_rs, lcd_d) - 32'd1;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end

        // End of execution wait chooses the next init entry, an inserted command, or IDLE.
        ST_WAIT: begin
          if (cnt_r == 32'd0) begin
            if (!init_done) begin
              if (init_idx_r == INIT_LAST) begin
                state_r   <= ST_IDLE;
                init_done <= 1'b1;
                req_ready <= 1'b1;
              end else begin
                state_r    <= ST_SETUP;
                cnt_r      <= SETUP_CYC - 32'd1;
                init_idx_r <= init_idx_r + 3'd1;
                lcd_rs     <= 1'b0;
                lcd_d      <= init_byte(init_idx_r + 3'd1);
              end
            end
`ifdef LCD_LINE_WRAP_EN
            else if (wrap_pend_r) begin
              state_r     <= ST_SETUP;
              cnt_r       <= SETUP_CYC - 32'd1;
              lcd_rs      <= 1'b0;
              lcd_d       <= line_r ? 8'h80 : 8'hC0;
              line_r      <= ~line_r;
              wrap_pend_r <= 1'b0;
            end
`endif
            else begin
              state_r   <= ST_IDLE;
              req_ready <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end

        default: begin
          state_r   <= ST_PWR;
          cnt_r     <= 32'd0;
          lcd_en    <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
